fs_inst_queue: RTL

//  Instruction queue between the IF and ID stages. Buffers {inst,pc} packets from IF
//  so fetch keeps running while ID stalls. Discards all wrong-path packets on a taken branch.
//  IF sees iq_allowin as its ds_allowin. ID sees iq_to_ds_valid/iq_to_ds_bus as fs_to_ds_*.

---
 rtl/fs_inst_queue_if.sv | 37 +++
 rtl/fs_inst_queue.sv | 62 ++++++
 2 files changed

// File: rtl/fs_inst_queue_if.sv
// IF/ID instruction queue handshake bundle.
// IF/ID drive the master side; the queue sits on the slave side.
interface fs_inst_queue_if #(
    parameter int BUS_WD = 64,
    parameter int PTR_WD = 2
);
    logic              fs_to_ds_valid;
    logic [BUS_WD-1:0] fs_to_ds_bus;
    logic              iq_allowin;
    logic              br_flush;
    logic              ds_allowin;
    logic              iq_to_ds_valid;
    logic [BUS_WD-1:0] iq_to_ds_bus;
    logic [PTR_WD:0]   iq_count;

    modport master (
        output fs_to_ds_valid,
        output fs_to_ds_bus,
        output br_flush,
        output ds_allowin,
        input  iq_allowin,
        input  iq_to_ds_valid,
        input  iq_to_ds_bus,
        input  iq_count
    );

    modport slave (
        input  fs_to_ds_valid,
        input  fs_to_ds_bus,
        input  br_flush,
        input  ds_allowin,
        output iq_allowin,
        output iq_to_ds_valid,
        output iq_to_ds_bus,
        output iq_count
    );
endinterface

// File: rtl/fs_inst_queue.sv
// Instruction queue between IF and ID: buffers {inst,pc} packets while ID
// stalls and discards wrong-path packets on a taken branch.
module fs_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int BUS_WD = 64,
    parameter int PTR_WD = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    fs_inst_queue_if.slave   q
);
    localparam logic [PTR_WD:0] FULL = (PTR_WD+1)'(DEPTH);

    logic [BUS_WD-1:0] r_mem [DEPTH];
    logic [PTR_WD-1:0] r_wr_ptr;
    logic [PTR_WD-1:0] r_rd_ptr;
    logic [PTR_WD:0]   r_count;

    logic              w_allowin;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic [PTR_WD:0]   w_push_ext;
    logic [PTR_WD:0]   w_pop_ext;

    // allowin is purely registered so IF never sees a path from ID or branch
    assign w_allowin  = (r_count != FULL);
    assign w_valid    = (r_count != '0) & ~q.br_flush;
    assign w_push     = q.fs_to_ds_valid & w_allowin & ~q.br_flush;
    assign w_pop      = w_valid & q.ds_allowin;
    assign w_push_ext = {{PTR_WD{1'b0}}, w_push};
    assign w_pop_ext  = {{PTR_WD{1'b0}}, w_pop};

    assign q.iq_allowin     = w_allowin;
    assign q.iq_to_ds_valid = w_valid;
    assign q.iq_to_ds_bus   = r_mem[r_rd_ptr];
    assign q.iq_count       = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (q.br_flush) begin
            // abandon entries in place; only the read side catches up
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= q.fs_to_ds_bus;
                r_wr_ptr        <= r_wr_ptr + PTR_WD'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WD'(1);
            end
            r_count <= r_count + w_push_ext - w_pop_ext;
        end
    end
endmodule
